// File: rtl/gray_fifo_pkg.sv
// rtl/gray_fifo_pkg.sv - Gray/binary helpers and depth derivation shared by the FIFO pointer blocks
package gray_fifo_pkg;

    localparam int HELPER_W = 32;

    function automatic int depth_of(input int ptr_w);
        return 1 << ptr_w;
    endfunction

    function automatic logic [HELPER_W-1:0] bin2gray(input logic [HELPER_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [HELPER_W-1:0] gray2bin(input logic [HELPER_W-1:0] g);
        logic [HELPER_W-1:0] b;
        b[HELPER_W-1] = g[HELPER_W-1];
        for (int i = HELPER_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input logic [HELPER_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < HELPER_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser, every stage synchronously reset to 0
module sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_status_tx.sv
// rtl/gray_ptr_sync_status_tx.sv - TX FIFO write-side read-pointer sync, occupancy status and error flags
module gray_ptr_sync_status_tx
    import gray_fifo_pkg::*;
#(
    parameter int PTR_W        = 12,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 4080
) (
    input  logic           i_wr_clk,
    input  logic           i_wr_rst,
    input  logic [PTR_W:0] i_rd_ptr_gray,
    input  logic [PTR_W:0] i_wr_ptr_bin,
    input  logic           i_err_clr,
    output logic [PTR_W:0] o_rd_ptr_gray,
    output logic [PTR_W:0] o_rd_ptr_bin,
    output logic [PTR_W:0] o_used,
    output logic [PTR_W:0] o_free,
    output logic           o_full,
    output logic           o_afull,
    output logic           o_gray_err,
    output logic           o_ovf_err
);

    localparam int             PW    = PTR_W + 1;
    localparam logic [PTR_W:0] DEPTH = PW'(depth_of(PTR_W));
    localparam logic [PTR_W:0] AFULL = PW'(AFULL_THRESH);

    logic [PTR_W:0] sync_gray;
    logic [PTR_W:0] rd_bin_q, rd_bin_d;
    logic [PTR_W:0] prev_gray_q;
    logic           cmp_valid_q;
    logic [PTR_W:0] used_q, used_d, free_q, free_d;
    logic           full_q, full_d, afull_q, afull_d;
    logic           gray_err_q, gray_err_d, ovf_err_q, ovf_err_d;
    logic [PTR_W:0] diff;
    logic           ovf_now, gray_bad;

    sync_chain #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .i_clk (i_wr_clk),
        .i_rst (i_wr_rst),
        .i_d   (i_rd_ptr_gray),
        .o_q   (sync_gray)
    );

    always_comb begin
        rd_bin_d = PW'(gray2bin(HELPER_W'(sync_gray)));
        // Modulo subtraction at pointer width absorbs the wrap bit naturally.
        diff     = i_wr_ptr_bin - rd_bin_q;
        ovf_now  = diff > DEPTH;
        used_d   = ovf_now ? DEPTH : diff;
        free_d   = DEPTH - used_d;
        full_d   = (used_d == DEPTH);
        afull_d  = (used_d >= AFULL);
        gray_bad = cmp_valid_q && (popcount(HELPER_W'(sync_gray ^ prev_gray_q)) > 6'd1);
        // A fresh error beats a simultaneous clear.
        gray_err_d = gray_bad | (gray_err_q & ~i_err_clr);
        ovf_err_d  = ovf_now  | (ovf_err_q  & ~i_err_clr);
    end

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_rst) begin
            rd_bin_q    <= '0;
            prev_gray_q <= '0;
            cmp_valid_q <= 1'b0;
            used_q      <= '0;
            free_q      <= DEPTH;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            gray_err_q  <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            prev_gray_q <= sync_gray;
            cmp_valid_q <= 1'b1;
            used_q      <= used_d;
            free_q      <= free_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            gray_err_q  <= gray_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign o_rd_ptr_gray = sync_gray;
    assign o_rd_ptr_bin  = rd_bin_q;
    assign o_used        = used_q;
    assign o_free        = free_q;
    assign o_full        = full_q;
    assign o_afull       = afull_q;
    assign o_gray_err    = gray_err_q;
    assign o_ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_gray_ptr_sync_status_tx.sv
// tb/tb_gray_ptr_sync_status_tx.sv - directed bench for the TX read-pointer sync/status block
module tb_gray_ptr_sync_status_tx;

    localparam int PTR_W = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [PTR_W:0] rd_gray, wr_bin;
    logic          err_clr;
    logic [PTR_W:0] o_rd_gray, o_rd_bin, o_used, o_free;
    logic          o_full, o_afull, o_gray_err, o_ovf_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_ptr_sync_status_tx #(
        .PTR_W        (PTR_W),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (4080)
    ) dut (
        .i_wr_clk      (clk),
        .i_wr_rst      (rst),
        .i_rd_ptr_gray (rd_gray),
        .i_wr_ptr_bin  (wr_bin),
        .i_err_clr     (err_clr),
        .o_rd_ptr_gray (o_rd_gray),
        .o_rd_ptr_bin  (o_rd_bin),
        .o_used        (o_used),
        .o_free        (o_free),
        .o_full        (o_full),
        .o_afull       (o_afull),
        .o_gray_err    (o_gray_err),
        .o_ovf_err     (o_ovf_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rd_gray = '0; wr_bin = 13'h0010; err_clr = 1'b0;

        // Test 1: reset then latency of a single Gray step 0 -> 1
        tick();
        chk("t1_rst_free", 32'(o_free), 32'h1000);
        chk("t1_rst_used", 32'(o_used), 32'h0);
        chk("t1_rst_gerr", 32'(o_gray_err), 32'h0);
        tick();
        tick();
        chk("t1_rst_free3", 32'(o_free), 32'h1000);
        rst = 1'b0; rd_gray = 13'h0001;
        tick();
        chk("t1_gray_c1", 32'(o_rd_gray), 32'h0);
        chk("t1_used_c1", 32'(o_used), 32'h010);
        tick();
        chk("t1_gray_c2", 32'(o_rd_gray), 32'h1);
        chk("t1_bin_c2", 32'(o_rd_bin), 32'h0);
        tick();
        chk("t1_bin_c3", 32'(o_rd_bin), 32'h1);
        chk("t1_used_c3", 32'(o_used), 32'h010);
        tick();
        chk("t1_used_c4", 32'(o_used), 32'h00F);
        chk("t1_free_c4", 32'(o_free), 32'hFF1);
        chk("t1_gerr", 32'(o_gray_err), 32'h0);

        // Test 2: exactly full
        rd_gray = 13'h0000; wr_bin = 13'h1000;
        tick();
        chk("t2_used_c1", 32'(o_used), 32'hFFF);
        tick(); tick(); tick();
        chk("t2_used", 32'(o_used), 32'h1000);
        chk("t2_free", 32'(o_free), 32'h0);
        chk("t2_full", 32'(o_full), 32'h1);
        chk("t2_afull", 32'(o_afull), 32'h1);
        chk("t2_ovf", 32'(o_ovf_err), 32'h0);

        // Test 3: wrap, rd binary 0x1FFD = Gray 0x1003 (also a 3-bit Gray jump from 0)
        rd_gray = 13'h1003; wr_bin = 13'h0005;
        tick(); tick(); tick(); tick();
        chk("t3_bin", 32'(o_rd_bin), 32'h1FFD);
        chk("t3_used", 32'(o_used), 32'h8);
        chk("t3_full", 32'(o_full), 32'h0);
        chk("t3_afull", 32'(o_afull), 32'h0);
        chk("t3_gerr", 32'(o_gray_err), 32'h1);
        chk("t3_ovf", 32'(o_ovf_err), 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_gerr_clr", 32'(o_gray_err), 32'h0);

        // Test 4: almost-full boundary 4079 -> 4080 -> 4079 against rd=0x1FFD
        wr_bin = 13'h0FEC;
        tick();
        chk("t4_used_4079", 32'(o_used), 32'hFEF);
        chk("t4_afull_4079", 32'(o_afull), 32'h0);
        wr_bin = 13'h0FED;
        tick();
        chk("t4_used_4080", 32'(o_used), 32'hFF0);
        chk("t4_afull_4080", 32'(o_afull), 32'h1);
        chk("t4_free_4080", 32'(o_free), 32'h010);
        wr_bin = 13'h0FEC;
        tick();
        chk("t4_afull_back", 32'(o_afull), 32'h0);

        // Test 5: 3-bit jump, then 2-bit jump coinciding with a clear
        rd_gray = 13'h1004;
        tick(); tick();
        chk("t5_gray_sync", 32'(o_rd_gray), 32'h1004);
        chk("t5_gerr_pre", 32'(o_gray_err), 32'h0);
        tick();
        chk("t5_gerr_set", 32'(o_gray_err), 32'h1);
        rd_gray = 13'h1007;
        tick();
        chk("t5_gerr_hold1", 32'(o_gray_err), 32'h1);
        tick();
        chk("t5_gray_sync2", 32'(o_rd_gray), 32'h1007);
        err_clr = 1'b1;
        tick();
        chk("t5_set_wins", 32'(o_gray_err), 32'h1);
        tick();
        chk("t5_clr", 32'(o_gray_err), 32'h0);
        err_clr = 1'b0;
        chk("t5_bin", 32'(o_rd_bin), 32'h1FFA);

        // Test 6: overflow wr-rd = 0x1002, sticky, then mid-run reset
        wr_bin = 13'h0FFC;
        tick();
        chk("t6_ovf", 32'(o_ovf_err), 32'h1);
        chk("t6_used_sat", 32'(o_used), 32'h1000);
        chk("t6_free", 32'(o_free), 32'h0);
        chk("t6_full", 32'(o_full), 32'h1);
        wr_bin = 13'h1FFA;
        tick();
        chk("t6_used_empty", 32'(o_used), 32'h0);
        chk("t6_ovf_sticky", 32'(o_ovf_err), 32'h1);
        wr_bin = 13'h0FFC;
        tick();
        rst = 1'b1; rd_gray = '0; wr_bin = '0;
        tick();
        chk("t6_rst_gray", 32'(o_rd_gray), 32'h0);
        chk("t6_rst_bin", 32'(o_rd_bin), 32'h0);
        chk("t6_rst_used", 32'(o_used), 32'h0);
        chk("t6_rst_free", 32'(o_free), 32'h1000);
        chk("t6_rst_full", 32'(o_full), 32'h0);
        chk("t6_rst_afull", 32'(o_afull), 32'h0);
        chk("t6_rst_ovf", 32'(o_ovf_err), 32'h0);
        chk("t6_rst_gerr", 32'(o_gray_err), 32'h0);
        rst = 1'b0;
        tick();
        chk("t6_post_gerr1", 32'(o_gray_err), 32'h0);
        tick(); tick(); tick();
        chk("t6_post_gerr4", 32'(o_gray_err), 32'h0);
        chk("t6_post_used", 32'(o_used), 32'h0);
        chk("t6_post_free", 32'(o_free), 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
